// File: rtl/core_seq_ctrl_pkg.sv
// core_seq_ctrl_pkg: state encoding and op-class constants shared by the sequencer files
package core_seq_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;
  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd7;
  function automatic logic is_illegal(input logic [2:0] c);
    return c == 3'd5 || c == 3'd6;
  endfunction
endpackage

// File: rtl/core_seq_ctrl_if.sv
// core_seq_ctrl_if: decoder/datapath-facing signals of the core sequencer
interface core_seq_ctrl_if #(
  parameter int IMW = 4,
  parameter int CW  = 16
);
  logic           run;
  logic           step;
  logic [2:0]     op_class;
  logic           br_taken;
  logic [IMW-1:0] br_target;
  logic           mem_ack;
  logic [IMW-1:0] pc;
  logic           imem_re;
  logic           ir_load;
  logic           alu_en;
  logic           mem_req;
  logic           mem_we;
  logic           rf_we;
  logic           retired;
  logic [CW-1:0]  instr_cnt;
  logic           halted;
  logic           err;
  modport master (
    input  run, step, op_class, br_taken, br_target, mem_ack,
    output pc, imem_re, ir_load, alu_en, mem_req, mem_we, rf_we, retired, instr_cnt, halted, err
  );
  modport slave (
    output run, step, op_class, br_taken, br_target, mem_ack,
    input  pc, imem_re, ir_load, alu_en, mem_req, mem_we, rf_we, retired, instr_cnt, halted, err
  );
endinterface

// File: rtl/core_seq_memwait.sv
// core_seq_memwait: counts MEM cycles without ack and flags the cycle that would reach MEM_TO
module core_seq_memwait #(
  parameter int MEM_TO = 8
) (
  input  logic clk,
  input  logic start,
  input  logic clr,
  input  logic en,
  input  logic mem_ack,
  output logic timeout
);
  localparam int W = $clog2(MEM_TO + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge start)
    if (!start) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // an ack in the final allowed cycle suppresses the timeout
  always_comb begin
    cnt_d = clr ? '0 : (en && !mem_ack) ? cnt_q + 1'b1 : cnt_q;
    timeout = en && !mem_ack && cnt_q == W'(MEM_TO - 1);
  end
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int IMW    = 4,
  parameter int CW     = 16,
  parameter int MEM_TO = 8
) (
  input logic           clk,
  input logic           start,
  core_seq_ctrl_if.master bus
);
  state_t         state_q, state_d;
  logic [IMW-1:0] pc_q, pc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     cls_q, cls_d;
  logic           err_q, err_d;
  logic           retire, timeout;
  core_seq_memwait #(.MEM_TO(MEM_TO)) u_memwait (
    .clk     (clk),
    .start   (start),
    .clr     (state_q != S_MEM),
    .en      (state_q == S_MEM),
    .mem_ack (bus.mem_ack),
    .timeout (timeout)
  );
  always_ff @(posedge clk or negedge start)
    if (!start) state_q <= S_IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge start)
    if (!start) begin
      pc_q  <= '0;
      cnt_q <= '0;
      cls_q <= OP_ALU;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      cls_q <= cls_d;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cls_d   = cls_q;
    err_d   = err_q | timeout;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = (bus.run || bus.step) ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        cls_d = bus.op_class;
        if (bus.op_class == OP_HALT) state_d = S_HALT;
        else if (is_illegal(bus.op_class)) begin
          err_d  = 1'b1;
          retire = 1'b1;
        end else state_d = S_EXEC;
      end
      S_EXEC:
        if (cls_q == OP_LOAD || cls_q == OP_STORE) state_d = S_MEM;
        else if (cls_q == OP_BRANCH || cls_q == OP_JUMP) begin
          retire = 1'b1;
          pc_d   = (cls_q == OP_JUMP || bus.br_taken) ? bus.br_target : pc_q + 1'b1;
        end else state_d = S_WB;
      S_MEM:
        if (bus.mem_ack) begin
          if (cls_q == OP_LOAD) state_d = S_WB;
          else retire = 1'b1;
        end else if (timeout) state_d = S_HALT;
      S_WB:     retire = 1'b1;
      default:  state_d = S_HALT;
    endcase
    // every retirement except a taken control transfer advances the PC by one
    if (retire) begin
      state_d = bus.run ? S_FETCH : S_IDLE;
      if (state_q != S_EXEC) pc_d = pc_q + 1'b1;
    end
    cnt_d = (retire && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    bus.pc        = pc_q;
    bus.imem_re   = state_q == S_FETCH;
    bus.ir_load   = state_q == S_DECODE;
    bus.alu_en    = state_q == S_EXEC;
    bus.mem_req   = state_q == S_MEM;
    bus.mem_we    = state_q == S_MEM && cls_q == OP_STORE;
    bus.rf_we     = state_q == S_WB;
    bus.retired   = retire;
    bus.instr_cnt = cnt_q;
    bus.halted    = state_q == S_HALT;
    bus.err       = err_q;
  end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed programs with a retire scoreboard checked by a separate monitor
module tb_core_seq_ctrl;
  typedef struct {
    int cyc;
    int pc;
    int cnt;
  } exp_t;
  logic clk = 1'b0;
  logic start = 1'b0;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  int n_req, n_we, n_rf, n_fetch, rf_cyc;
  int ack_dly = -1;
  int mc = 0;
  bit ack_tied = 1'b0;
  bit pend = 1'b0;
  exp_t sb[$];
  exp_t exp_e;
  logic [2:0] cls_m [16];
  logic       tk_m  [16];
  logic [3:0] tg_m  [16];
  core_seq_ctrl_if #(.IMW(4), .CW(16)) bus ();
  core_seq_ctrl #(.IMW(4), .CW(16), .MEM_TO(8)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  assign bus.op_class  = cls_m[bus.pc];
  assign bus.br_taken  = tk_m[bus.pc];
  assign bus.br_target = tg_m[bus.pc];
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (pend) begin
      chk("ret_pc", int'(bus.pc), exp_e.pc);
      chk("ret_cnt", int'(bus.instr_cnt), exp_e.cnt);
      pend = 1'b0;
    end
    if (bus.retired) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_retire: got retire at pc %0d, expected none", bus.pc);
      end else begin
        exp_e = sb.pop_front();
        chk("ret_cyc", cyc, exp_e.cyc);
        pend = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (ack_tied) bus.mem_ack = 1'b1;
    else if (bus.mem_req) begin
      bus.mem_ack = (ack_dly >= 0 && mc == ack_dly);
      mc++;
    end else begin
      bus.mem_ack = 1'b0;
      mc = 0;
    end
  end
  always @(negedge clk) begin
    n_req   += int'(bus.mem_req);
    n_we    += int'(bus.mem_we);
    n_rf    += int'(bus.rf_we);
    n_fetch += int'(bus.imem_re);
    if (bus.rf_we && rf_cyc < 0) rf_cyc = cyc;
  end
  task automatic clr_counts();
    n_req = 0;
    n_we = 0;
    n_rf = 0;
    n_fetch = 0;
    rf_cyc = -1;
  endtask
  task automatic clr_prog();
    for (int i = 0; i < 16; i++) begin
      cls_m[i] = 3'd7;
      tk_m[i] = 1'b0;
      tg_m[i] = 4'd0;
    end
  endtask
  task automatic do_reset();
    start = 1'b0;
    bus.run = 1'b0;
    bus.step = 1'b0;
    ack_tied = 1'b0;
    ack_dly = -1;
    clr_prog();
    repeat (2) @(negedge clk);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_cnt", int'(bus.instr_cnt), 0);
    chk("rst_flags", int'({bus.halted, bus.err}), 0);
    chk("rst_en", int'({bus.imem_re, bus.ir_load, bus.alu_en, bus.mem_req, bus.mem_we, bus.rf_we, bus.retired}), 0);
    start = 1'b1;
    @(negedge clk);
    clr_counts();
  endtask
  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.halted) return;
    end
    total++;
    $display("FAIL halt_wait: got no halt within %0d cycles, expected halted=1", budget);
  endtask
  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.mem_req) return;
    end
    total++;
    $display("FAIL req_wait: got no mem_req within %0d cycles, expected mem_req=1", budget);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end
  initial begin
    // ALU, ALU, HALT with ack tied high
    do_reset();
    cls_m[0] = 3'd0;
    cls_m[1] = 3'd0;
    ack_tied = 1'b1;
    sb.push_back('{4, 1, 1});
    sb.push_back('{8, 2, 2});
    cyc = 0;
    bus.run = 1'b1;
    wait_halt(40);
    chk("t1_halt_cyc", cyc, 11);
    chk("t1_cnt", int'(bus.instr_cnt), 2);
    chk("t1_pc", int'(bus.pc), 2);
    chk("t1_err", int'(bus.err), 0);
    repeat (3) @(negedge clk);
    chk("t1_frozen_pc", int'(bus.pc), 2);
    chk("t1_halt_en", int'({bus.imem_re, bus.ir_load, bus.alu_en, bus.mem_req, bus.rf_we, bus.halted}), 1);
    // LOAD with ack on the fourth MEM cycle
    do_reset();
    cls_m[0] = 3'd1;
    ack_dly = 3;
    sb.push_back('{8, 1, 1});
    cyc = 0;
    bus.run = 1'b1;
    wait_halt(40);
    chk("t2_req_cycles", n_req, 4);
    chk("t2_we_cycles", n_we, 0);
    chk("t2_rf_cycles", n_rf, 1);
    chk("t2_rf_cyc", rf_cyc, 8);
    chk("t2_pc", int'(bus.pc), 1);
    chk("t2_cnt", int'(bus.instr_cnt), 1);
    // STORE never acknowledged: timeout after 8 MEM cycles
    do_reset();
    cls_m[0] = 3'd2;
    cyc = 0;
    bus.run = 1'b1;
    wait_halt(40);
    chk("t3_halt_cyc", cyc, 12);
    repeat (2) @(negedge clk);
    chk("t3_req_cycles", n_req, 8);
    chk("t3_we_cycles", n_we, 8);
    chk("t3_flags", int'({bus.halted, bus.err}), 3);
    chk("t3_cnt", int'(bus.instr_cnt), 0);
    chk("t3_pc", int'(bus.pc), 0);
    // single step of a JUMP to 15, step re-raised during EXEC
    do_reset();
    cls_m[0] = 3'd4;
    tg_m[0] = 4'd15;
    sb.push_back('{3, 15, 1});
    cyc = 0;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_fetches", n_fetch, 1);
    chk("t4_step_pc", int'(bus.pc), 15);
    chk("t4_step_cnt", int'(bus.instr_cnt), 1);
    // branches and jump from pc 15 under run
    cls_m[15] = 3'd3; tk_m[15] = 1'b0; tg_m[15] = 4'd7;
    cls_m[0]  = 3'd3; tk_m[0]  = 1'b1; tg_m[0]  = 4'd9;
    cls_m[9]  = 3'd4; tg_m[9]  = 4'd3;
    sb.push_back('{3, 0, 2});
    sb.push_back('{6, 9, 3});
    sb.push_back('{9, 3, 4});
    cyc = 0;
    bus.run = 1'b1;
    wait_halt(40);
    chk("t4_pc", int'(bus.pc), 3);
    chk("t4_cnt", int'(bus.instr_cnt), 4);
    chk("t4_err", int'(bus.err), 0);
    // reset asserted mid-MEM, then illegal op under run
    do_reset();
    cls_m[0] = 3'd0;
    cls_m[1] = 3'd1;
    sb.push_back('{4, 1, 1});
    cyc = 0;
    bus.run = 1'b1;
    wait_req(20);
    repeat (2) @(negedge clk);
    #2 start = 1'b0;
    #1;
    chk("t5_rst_req", int'(bus.mem_req), 0);
    chk("t5_rst_pc", int'(bus.pc), 0);
    chk("t5_rst_cnt", int'(bus.instr_cnt), 0);
    chk("t5_rst_err", int'(bus.err), 0);
    bus.run = 1'b0;
    @(negedge clk);
    start = 1'b1;
    clr_counts();
    repeat (3) @(negedge clk);
    chk("t5_idle_fetch", n_fetch, 0);
    clr_prog();
    cls_m[0] = 3'd5;
    cls_m[1] = 3'd0;
    sb.push_back('{2, 1, 1});
    sb.push_back('{6, 2, 2});
    cyc = 0;
    bus.run = 1'b1;
    wait_halt(40);
    chk("t5_flags", int'({bus.halted, bus.err}), 3);
    chk("t5_pc", int'(bus.pc), 2);
    chk("t5_cnt", int'(bus.instr_cnt), 2);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
